// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS core, with RUN/HALT/ERR control.
// Defining PC_BRANCH_STATS_EN adds saturating branch_cnt/taken_cnt counters.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            branch_taken,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic            is_jr,
    input  logic [15:0]     imm16,
    input  logic [25:0]     jaddr26,
    input  logic [PC_W-1:0] rs_data,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            halted,
    output logic            misaligned
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     taken_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] branch_off;
    logic [PC_W-1:0] branch_tgt;
    logic [PC_W-1:0] jump_tgt;
    logic [PC_W-1:0] next_pc;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign branch_tgt = pc_plus4 + branch_off;
    assign jump_tgt   = {pc_plus4[31:28], jaddr26, 2'b00};

    // Only jr can produce a misaligned target; the other sources are aligned by construction.
    always_comb begin
        next_pc = pc_plus4;
        if (is_jr)
            next_pc = rs_data;
        else if (is_jump)
            next_pc = jump_tgt;
        else if (is_branch && branch_taken)
            next_pc = branch_tgt;
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        if (en) begin
            case (state)
                ST_RUN: begin
                    if (halt_req)
                        state_d = ST_HALT;
                    else if (next_pc[1:0] != 2'b00)
                        state_d = ST_ERR;
                    else
                        pc_d = next_pc;
                end
                ST_HALT: begin
                    if (resume && !halt_req)
                        state_d = ST_RUN;
                end
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    assign halted     = (state == ST_HALT);
    assign misaligned = (state == ST_ERR);

`ifdef PC_BRANCH_STATS_EN
    logic branch_evt;
    logic taken_evt;

    assign branch_evt = en && (state == ST_RUN) && !halt_req && is_branch;
    assign taken_evt  = branch_evt && branch_taken && (next_pc[1:0] == 2'b00);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= 32'd0;
            taken_cnt  <= 32'd0;
        end else begin
            if (branch_evt && (branch_cnt != 32'hFFFF_FFFF))
                branch_cnt <= branch_cnt + 32'd1;
            if (taken_evt && (taken_cnt != 32'hFFFF_FFFF))
                taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule
